// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the strided convolution scheduler.
package conv_pkg;

   localparam int DATA_W = 32;
   localparam int FRAC_W = 15;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_F,
      LOAD_X,
      COMPUTE,
      EMIT,
      FIN
   } state_t;

   function automatic int out_dim(input int n, input int f, input int s);
      return (n - f) / s + 1;
   endfunction

   // Wide enough that F*F full-width products can never overflow the sum.
   function automatic int acc_w(input int f);
      return 64 + $clog2(f * f);
   endfunction

endpackage

// File: rtl/conv_mac.sv
// Single signed Q16.15 multiply-accumulate lane with final rescale.
// CONV_SAT_EN selects saturating rather than wrapping 32-bit results.
module conv_mac
   import conv_pkg::*;
#(
   parameter int AW = 69
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     en,
   input  logic signed [DATA_W-1:0] a,
   input  logic signed [DATA_W-1:0] b,
   output logic        [DATA_W-1:0] result
);

   logic signed [63:0]   prod;
   logic signed [AW-1:0] acc;
   logic signed [AW-1:0] sum;

   assign prod = a * b;
   assign sum  = acc + {{(AW-64){prod[63]}}, prod};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (clear) begin
         acc <= '0;
      end else if (en) begin
         acc <= sum;
      end
   end

   // result includes the current tap so the last-tap cycle can register it directly
`ifdef CONV_SAT_EN
   logic signed [AW-1:0] shifted;

   assign shifted = sum >>> FRAC_W;

   always_comb begin
      result = shifted[DATA_W-1:0];
      if (shifted[AW-1:DATA_W-1] != {(AW-DATA_W+1){shifted[AW-1]}}) begin
         result = shifted[AW-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
   end
`else
   assign result = sum[FRAC_W +: DATA_W];
`endif

endmodule

// File: rtl/conv_sched.sv
// Sequential convolution scheduler: stream-loads filter and tile, then runs one
// MAC per cycle over every window. Result saturation is controlled by CONV_SAT_EN.
module conv_sched
   import conv_pkg::*;
#(
   parameter int FILTER_SIZE = 5,
   parameter int INPUT_SIZE  = 7,
   parameter int STRIDE      = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              busy,
   output logic              done
);

   localparam int OUT_SIZE = out_dim(INPUT_SIZE, FILTER_SIZE, STRIDE);
   localparam int AW       = acc_w(FILTER_SIZE);
   localparam int F2       = FILTER_SIZE * FILTER_SIZE;
   localparam int N2       = INPUT_SIZE * INPUT_SIZE;
   localparam int CW       = $clog2(N2 + 1);

   state_t state, state_next;

   logic [DATA_W-1:0] filt_buf [F2];
   logic [DATA_W-1:0] x_buf    [N2];

   logic [CW-1:0] load_cnt, kr, kc, orow, ocol;
   logic [CW-1:0] f_addr, x_addr;
   logic          in_hs, out_hs;
   logic          last_f, last_x, last_tap, last_out;
   logic [DATA_W-1:0] mac_result;

   assign in_hs    = in_valid && in_ready;
   assign out_hs   = out_valid && out_ready;
   assign last_f   = (load_cnt == CW'(F2 - 1));
   assign last_x   = (load_cnt == CW'(N2 - 1));
   assign last_tap = (kr == CW'(FILTER_SIZE - 1)) && (kc == CW'(FILTER_SIZE - 1));
   assign last_out = (orow == CW'(OUT_SIZE - 1)) && (ocol == CW'(OUT_SIZE - 1));

   assign f_addr = CW'(int'(kr) * FILTER_SIZE + int'(kc));
   assign x_addr = CW'((int'(orow) * STRIDE + int'(kr)) * INPUT_SIZE
                       + int'(ocol) * STRIDE + int'(kc));

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      done       = 1'b0;
      busy       = (state != IDLE);
      unique case (state)
         IDLE:    if (start) state_next = LOAD_F;
         LOAD_F: begin
            in_ready = 1'b1;
            if (in_valid && last_f) state_next = LOAD_X;
         end
         LOAD_X: begin
            in_ready = 1'b1;
            if (in_valid && last_x) state_next = COMPUTE;
         end
         COMPUTE: if (last_tap) state_next = EMIT;
         EMIT: begin
            out_valid = 1'b1;
            if (out_ready) state_next = last_out ? FIN : COMPUTE;
         end
         FIN: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         load_cnt <= '0;
         kr       <= '0;
         kc       <= '0;
         orow     <= '0;
         ocol     <= '0;
         out_data <= '0;
      end else begin
         state <= state_next;
         case (state)
            LOAD_F: if (in_hs) load_cnt <= last_f ? '0 : load_cnt + 1'b1;
            LOAD_X: begin
               if (in_hs) begin
                  load_cnt <= last_x ? '0 : load_cnt + 1'b1;
                  if (last_x) begin
                     kr   <= '0;
                     kc   <= '0;
                     orow <= '0;
                     ocol <= '0;
                  end
               end
            end
            COMPUTE: begin
               if (kc == CW'(FILTER_SIZE - 1)) begin
                  kc <= '0;
                  kr <= last_tap ? '0 : kr + 1'b1;
               end else begin
                  kc <= kc + 1'b1;
               end
               if (last_tap) out_data <= mac_result;
            end
            EMIT: begin
               if (out_hs) begin
                  if (ocol == CW'(OUT_SIZE - 1)) begin
                     ocol <= '0;
                     orow <= last_out ? '0 : orow + 1'b1;
                  end else begin
                     ocol <= ocol + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Buffers need no reset; they are fully rewritten before each job reads them.
   always_ff @(posedge clk) begin
      if (in_hs && state == LOAD_F) filt_buf[load_cnt] <= in_data;
      if (in_hs && state == LOAD_X) x_buf[load_cnt]    <= in_data;
   end

   conv_mac #(.AW(AW)) u_mac (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (state != COMPUTE),
      .en     (state == COMPUTE),
      .a      (filt_buf[f_addr]),
      .b      (x_buf[x_addr]),
      .result (mac_result)
   );

endmodule

// File: tb/tb_conv_sched.sv
// Directed self-checking bench for conv_sched at default sizes (F=5, N=7, S=2).
module tb_conv_sched;

   localparam int F2 = 25;
   localparam int N2 = 49;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        busy;
   logic        done;

   int testsRun  = 0;
   int failCount = 0;
   int cycleCount = 0;

   conv_sched dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycleCount <= cycleCount + 1;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // Pulse start, then stream the filter and tile with even/odd index patterns.
   task automatic applyStimulus(input logic [31:0] fEven, input logic [31:0] fOdd,
                                input logic [31:0] xEven, input logic [31:0] xOdd);
      int guard;
      start = 1'b1;
      stepCycle();
      start = 1'b0;
      for (int i = 0; i < F2 + N2; i++) begin
         if (i < F2) in_data = i[0] ? fOdd : fEven;
         else        in_data = (i - F2) % 2 == 1 ? xOdd : xEven;
         in_valid = 1'b1;
         guard = 0;
         while (!in_ready && guard < 20) begin
            stepCycle();
            guard++;
         end
         if (guard >= 20) checkOutput("in_ready_timeout", {31'b0, in_ready}, 32'd1);
         stepCycle();
      end
      in_valid = 1'b0;
      in_data  = '0;
   endtask

   // Accept count outputs with out_ready high, optionally checking 26-cycle spacing.
   task automatic collectOutputs(input logic [31:0] expected, input int count, input bit checkSpacing);
      int guard;
      int lastRise;
      out_ready = 1'b1;
      lastRise  = 0;
      for (int o = 0; o < count; o++) begin
         guard = 0;
         while (!out_valid && guard < 100) begin
            stepCycle();
            guard++;
         end
         checkOutput($sformatf("out_valid_%0d", o), {31'b0, out_valid}, 32'd1);
         checkOutput($sformatf("out_data_%0d", o), out_data, expected);
         if (checkSpacing && o > 0)
            checkOutput($sformatf("spacing_%0d", o), cycleCount - lastRise, 32'd26);
         lastRise = cycleCount;
         stepCycle();
      end
      checkOutput("done_pulse", {31'b0, done}, 32'd1);
      checkOutput("out_valid_after_last", {31'b0, out_valid}, 32'd0);
      stepCycle();
      checkOutput("done_cleared", {31'b0, done}, 32'd0);
      checkOutput("busy_cleared", {31'b0, busy}, 32'd0);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] satExpected;
      int guard;

      rst_n     = 1'b0;
      start     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      #3;
      checkOutput("reset_in_ready",  {31'b0, in_ready},  32'd0);
      checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("reset_busy",      {31'b0, busy},      32'd0);
      checkOutput("reset_done",      {31'b0, done},      32'd0);
      checkOutput("reset_out_data",  out_data,           32'd0);
      stepCycle();
      stepCycle();
      rst_n = 1'b1;
      stepCycle();

      // in_valid alone in IDLE must not start anything
      in_valid = 1'b1;
      stepCycle();
      checkOutput("idle_ignores_valid", {31'b0, busy}, 32'd0);
      in_valid = 1'b0;

      $display("[TB] checkerboard 1.0 pattern");
      applyStimulus(32'h0, 32'h0000_8000, 32'h0, 32'h0000_8000);
      collectOutputs(32'h0006_0000, 4, 1'b0);

      $display("[TB] all ones, spacing");
      applyStimulus(32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 32'h0000_8000);
      collectOutputs(32'h000C_8000, 4, 1'b1);

      $display("[TB] negative filter");
      applyStimulus(32'hFFFF_8000, 32'hFFFF_8000, 32'h0001_0000, 32'h0001_0000);
      collectOutputs(32'hFFE7_0000, 4, 1'b0);

      $display("[TB] backpressure");
      out_ready = 1'b0;
      applyStimulus(32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 32'h0000_8000);
      guard = 0;
      while (!out_valid && guard < 100) begin
         stepCycle();
         guard++;
      end
      for (int c = 0; c < 10; c++) begin
         checkOutput($sformatf("bp_valid_%0d", c), {31'b0, out_valid}, 32'd1);
         checkOutput($sformatf("bp_data_%0d", c), out_data, 32'h000C_8000);
         stepCycle();
      end
      out_ready = 1'b1;
      stepCycle();
      checkOutput("bp_released", {31'b0, out_valid}, 32'd0);
      collectOutputs(32'h000C_8000, 3, 1'b0);

      $display("[TB] reset mid-compute");
      out_ready = 1'b1;
      applyStimulus(32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 32'h0000_8000);
      guard = 0;
      while (!out_valid && guard < 100) begin
         stepCycle();
         guard++;
      end
      stepCycle();
      repeat (10) stepCycle();
      rst_n = 1'b0;
      #1;
      checkOutput("mid_reset_busy",      {31'b0, busy},      32'd0);
      checkOutput("mid_reset_out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("mid_reset_out_data",  out_data,           32'd0);
      checkOutput("mid_reset_in_ready",  {31'b0, in_ready},  32'd0);
      stepCycle();
      rst_n = 1'b1;
      stepCycle();
      applyStimulus(32'h0, 32'h0000_8000, 32'h0, 32'h0000_8000);
      collectOutputs(32'h0006_0000, 4, 1'b0);

      $display("[TB] large operands");
`ifdef CONV_SAT_EN
      satExpected = 32'h7FFF_FFFF;
`else
      satExpected = 32'h8000_0000;
`endif
      applyStimulus(32'h0080_0000, 32'h0080_0000, 32'h0080_0000, 32'h0080_0000);
      collectOutputs(satExpected, 4, 1'b0);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
